// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-latched pending bits, maskable, traps user code only.
// Optional INTERRUPT_COUNTER_EN adds a saturating 16-bit interrupt_count output.
module interrupt_controller #(
  parameter int unsigned          NUM_SOURCES   = 4,
  parameter int unsigned          PC_WIDTH      = 16,
  parameter logic [PC_WIDTH-1:0]  VECTOR_BASE   = PC_WIDTH'('h0040),
  parameter int unsigned          VECTOR_STRIDE = 4,
  localparam int unsigned         CAUSE_WIDTH   = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_lines,
  input  logic                   is_Bios,
  input  logic                   is_kernel,
  input  logic                   mask_write,
  input  logic [NUM_SOURCES-1:0] mask_data,
  input  logic                   instruction_done,
  input  logic [PC_WIDTH-1:0]    current_pc,
  input  logic                   interrupt_return,
  output logic                   take_interrupt,
  output logic [PC_WIDTH-1:0]    handler_address,
  output logic [PC_WIDTH-1:0]    return_address,
  output logic [CAUSE_WIDTH-1:0] interrupt_cause,
  output logic                   in_service,
  output logic [NUM_SOURCES-1:0] pending
`ifdef INTERRUPT_COUNTER_EN
  ,
  output logic [15:0]            interrupt_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_SOURCES-1:0] prev_lines_q, prev_lines_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] mask_q, mask_d;
  logic                   take_q, take_d;
  logic [PC_WIDTH-1:0]    handler_q, handler_d;
  logic [PC_WIDTH-1:0]    return_q, return_d;
  logic [CAUSE_WIDTH-1:0] cause_q, cause_d;

  logic [NUM_SOURCES-1:0] rise;
  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] clear;
  logic                   user;
  logic                   sel_found;
  logic [CAUSE_WIDTH-1:0] sel_cause;

  // Lowest-index eligible source wins.
  always_comb begin
    rise      = irq_lines & ~prev_lines_q;
    eligible  = pending_q & mask_q;
    user      = !is_Bios && !is_kernel;
    sel_found = 1'b0;
    sel_cause = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (eligible[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_cause = CAUSE_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    take_d    = 1'b0;
    handler_d = handler_q;
    return_d  = return_q;
    cause_d   = cause_q;
    clear     = '0;
    case (state_q)
      IDLE: begin
        if ((eligible != '0) && user) state_d = ARMED;
      end
      ARMED: begin
        if ((eligible == '0) || !user) begin
          state_d = IDLE;
        end else if (instruction_done) begin
          state_d   = SERVICE;
          take_d    = 1'b1;
          cause_d   = sel_cause;
          clear     = NUM_SOURCES'(1) << sel_cause;
          return_d  = current_pc;
          handler_d = VECTOR_BASE + PC_WIDTH'(sel_cause) * PC_WIDTH'(VECTOR_STRIDE);
        end
      end
      SERVICE: begin
        if (interrupt_return) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge on the bit being taken keeps it pending (set wins).
  always_comb begin
    pending_d    = (pending_q & ~clear) | rise;
    prev_lines_d = irq_lines;
    mask_d       = mask_write ? mask_data : mask_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_lines_q <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      take_q       <= 1'b0;
      handler_q    <= '0;
      return_q     <= '0;
      cause_q      <= '0;
    end else begin
      state_q      <= state_d;
      prev_lines_q <= prev_lines_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      take_q       <= take_d;
      handler_q    <= handler_d;
      return_q     <= return_d;
      cause_q      <= cause_d;
    end
  end

  assign take_interrupt  = take_q;
  assign handler_address = handler_q;
  assign return_address  = return_q;
  assign interrupt_cause = cause_q;
  assign in_service      = (state_q == SERVICE);
  assign pending         = pending_q;

`ifdef INTERRUPT_COUNTER_EN
  logic [15:0] count_q, count_d;

  // Counts at the edge that raises take_interrupt, so it tracks the pulse.
  always_comb begin
    count_d = count_q;
    if (take_d && (count_q != '1)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign interrupt_count = count_q;
`endif

endmodule
